overlay_pixel_gen: RTL and testbench
====================================

# overlay_pixel_gen

Pixel-data stage directly downstream of the 1080p timing generator. Consumes its de/hs/vs on the pixel clock, tracks active-area x/y position, and produces 24-bit RGB: eight vertical colour bars with a configurable rectangular overlay box (solid or 50 % blended, with border). Syncs are delayed to stay aligned with the pixel data before going to the HDMI transmitter.

## Interface
- H_ACTIVE, 1920, active pixels per line; x-counter range 0..H_ACTIVE-1
- V_ACTIVE, 1080, active lines per frame
- BAR_W, 240, colour-bar width in pixels
- BORDER_W, 2, overlay border thickness in pixels
- clk  in  1  pixel clock (timing generator's pclk)
- reset_n  in  1  asynchronous, active-low reset
- in_de / in_hs / in_vs  in  1 each  timing from generator, active-high
- box_x, box_y  in  12 each  overlay top-left corner (active-area coordinates)
- box_w, box_h  in  12 each  overlay size; 0 disables overlay
- box_rgb  in  24  overlay fill colour {R,G,B}
- border_rgb  in  24  overlay border colour
- blend_en  in  1  1 = fill is (fill+bar)/2 per channel; 0 = opaque
- vga_de / vga_hs / vga_vs  out  1 each  delayed timing
- vga_r / vga_g / vga_b  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse on in_vs rising edge

## Operation
- Position FSM: V_BLANK → LINE_WAIT → ACTIVE → LINE_WAIT …
  - any state, in_vs rising edge → V_BLANK; y=0, shadow registers load.
  - V_BLANK/LINE_WAIT, in_de=1 → ACTIVE, x=0 on that pixel.
  - ACTIVE, in_de=1 → x+1; saturates at H_ACTIVE-1 (never wraps).
  - ACTIVE, in_de=0 → LINE_WAIT, y+1; y saturates at V_ACTIVE-1.
- Shadow registers: box_*, box_rgb, border_rgb, blend_en captured only on in_vs rising edge; mid-frame input changes take effect next frame. Reset value: box_w=box_h=0 (overlay off).
- Bar index = x / BAR_W via running bar counter (no divider): resets at x=0, increments when intra-bar count reaches BAR_W-1; index saturates at 7. Colours 0..7: white, yellow, cyan, green, magenta, red, blue, black (channels 0xFF/0x00).
- Inside box: box_x ≤ x < box_x+box_w and box_y ≤ y < box_y+box_h, 13-bit compare (no overflow when box extends past screen edge; clipped naturally).
- Border: inside box and within BORDER_W of any box edge → border_rgb, never blended. If box_w or box_h ≤ 2·BORDER_W, whole box is border.
- Fill: blend_en ? ((box+bar)>>1) per channel, 9-bit sum truncated : box_rgb.
- vga_r/g/b forced to 0 whenever vga_de=0.

## Timing
- Latency: 2 cycles input → output for all of de/hs/vs/RGB; syncs pass through a 2-stage shift register, no modification.
- Stage 1: x/y/bar registered, box compares registered. Stage 2: colour mux/blend registered.
- frame_start: registered, asserted the cycle after in_vs is first sampled high (same cycle as stage-1 reset of y).
- Reset (async assert, sync release via clk): all outputs 0, FSM V_BLANK, x=y=0, pipeline cleared. First frame after reset needs an in_vs edge; de before that is still output with y counting from 0.
- Simultaneous in_vs rise and in_de=1: vs wins; y=0, x=0 and FSM enters ACTIVE next in_de cycle.

## Structure
- Package overlay_pkg: bar colour constant array, RGB 24-bit typedef, FSM state enum.
- One sub-module: overlay_box_cmp (registered in-box / on-border decision from x, y, shadowed geometry).

## Test plan
- Reset mid-line with de high → all outputs 0 next clk, FSM V_BLANK; after release, first vga_de 2 cycles after in_de.
- Full 1080p frame (2200×1125, box 0 size) → pixel x=0: FFFFFF; x=240: FFFF00; x=1919: 000000; 1920×1080 de cycles.
- Box (100,50,200,100), box_rgb 0000FF, border FF0000, blend off → (100,50)=FF0000, (101,51)=FF0000, (102,52)=0000FF, (300,50)=bar colour.
- Same box, blend_en=1 over white bar → fill 7F7FFF.
- Change box_x to 500 mid-frame → current frame unchanged; next frame box at 500.
- Box (1900,1070,100,100) → clipped, no wrap artefacts at x=0/y=0; box_w=4 → all pixels border colour.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay pixel generator.
//   rgb_t        : 24-bit {r,g,b} pixel
//   pos_state_t  : raster position FSM states
//   BAR_COLOURS  : colour-bar palette, index 0 (left) .. 7 (right)
//   blend_half   : per-channel (a+b)>>1 with 9-bit intermediate sum
package overlay_pkg;

  localparam int unsigned H_ACTIVE  = 1920;
  localparam int unsigned V_ACTIVE  = 1080;
  localparam int unsigned BAR_W     = 240;
  localparam int unsigned BORDER_W  = 2;
  localparam int unsigned NUM_BARS  = 8;
  localparam int unsigned CW        = 12;  // coordinate / geometry width
  localparam int unsigned BAR_CNT_W = 8;   // intra-bar pixel counter
  localparam int unsigned BAR_IDX_W = 3;   // bar index 0..7
  localparam int unsigned RGB_W     = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_V_BLANK   = 2'd0,
    ST_LINE_WAIT = 2'd1,
    ST_ACTIVE    = 2'd2
  } pos_state_t;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [RGB_W-1:0] BAR_COLOURS [NUM_BARS] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic rgb_t blend_half(input rgb_t a, input rgb_t b);
    logic [8:0] sr;
    logic [8:0] sg;
    logic [8:0] sb;
    rgb_t       res;
    sr    = 9'(a.r) + 9'(b.r);
    sg    = 9'(a.g) + 9'(b.g);
    sb    = 9'(a.b) + 9'(b.b);
    res.r = sr[8:1];
    res.g = sg[8:1];
    res.b = sb[8:1];
    return res;
  endfunction

endpackage

// File: rtl/overlay_box_cmp.sv
// Registered overlay hit test for the pixel at (x, y).
//   clk, reset_n          : pixel clock, async active-low reset
//   x, y                  : active-area position of the current pixel
//   box_x/box_y/box_w/box_h : shadowed overlay geometry (w or h = 0 disables)
//   in_box                : pixel lies inside the overlay rectangle
//   on_border             : pixel lies inside the rectangle and on its border
module overlay_box_cmp
  import overlay_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] box_x,
  input  logic [CW-1:0] box_y,
  input  logic [CW-1:0] box_w,
  input  logic [CW-1:0] box_h,
  output logic          in_box,
  output logic          on_border
);

  // One extra bit so box_x+box_w past the screen edge cannot wrap.
  localparam int unsigned EW = CW + 1;

  logic [EW-1:0] x_e, y_e;
  logic [EW-1:0] right_e, bottom_e;
  logic          in_x, in_y, near_x, near_y, thin;
  logic          hit_c, edge_c;

  always_comb begin
    x_e      = EW'(x);
    y_e      = EW'(y);
    right_e  = EW'(box_x) + EW'(box_w);
    bottom_e = EW'(box_y) + EW'(box_h);
    in_x     = (x_e >= EW'(box_x)) && (x_e < right_e);
    in_y     = (y_e >= EW'(box_y)) && (y_e < bottom_e);
    // Far-edge test written as x+BORDER_W >= right to avoid underflow.
    near_x   = (x_e < EW'(box_x) + EW'(BORDER_W)) || (x_e + EW'(BORDER_W) >= right_e);
    near_y   = (y_e < EW'(box_y) + EW'(BORDER_W)) || (y_e + EW'(BORDER_W) >= bottom_e);
    thin     = (box_w <= CW'(2 * BORDER_W)) || (box_h <= CW'(2 * BORDER_W));
    hit_c    = in_x && in_y;
    edge_c   = hit_c && (thin || near_x || near_y);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box    <= 1'b0;
      on_border <= 1'b0;
    end else begin
      in_box    <= hit_c;
      on_border <= edge_c;
    end
  end

endmodule

// File: rtl/overlay_pixel_gen.sv
// Colour-bar + overlay-box pixel generator behind the 1080p timing generator.
//   clk, reset_n            : pixel clock, async active-low reset
//   in_de/in_hs/in_vs       : timing from the generator
//   box_x/box_y/box_w/box_h : overlay geometry (sampled at in_vs rise)
//   box_rgb, border_rgb     : overlay fill / border colour (sampled at in_vs rise)
//   blend_en                : 50 % blend of fill over bars (sampled at in_vs rise)
//   vga_de/vga_hs/vga_vs    : timing delayed 2 cycles
//   vga_r/vga_g/vga_b       : pixel colour, 0 outside active video
//   frame_start             : one-cycle pulse after in_vs rises
module overlay_pixel_gen
  import overlay_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_de,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic [CW-1:0]    box_x,
  input  logic [CW-1:0]    box_y,
  input  logic [CW-1:0]    box_w,
  input  logic [CW-1:0]    box_h,
  input  logic [RGB_W-1:0] box_rgb,
  input  logic [RGB_W-1:0] border_rgb,
  input  logic             blend_en,
  output logic             vga_de,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             frame_start
);

  pos_state_t           state;
  logic                 vs_prev;
  logic                 vs_rise;
  logic [CW-1:0]        x_q, y_q;
  logic [BAR_CNT_W-1:0] bar_cnt_q;
  logic [BAR_IDX_W-1:0] bar_idx_q;

  logic [CW-1:0]        pix_x, pix_y;
  logic [BAR_CNT_W-1:0] pix_cnt;
  logic [BAR_IDX_W-1:0] pix_idx;

  logic [CW-1:0]        sh_box_x, sh_box_y, sh_box_w, sh_box_h;
  rgb_t                 sh_box_rgb, sh_border_rgb;
  logic                 sh_blend;

  logic                 s1_de, s1_hs, s1_vs;
  logic [BAR_IDX_W-1:0] s1_bar;
  logic                 s1_in_box, s1_on_border;

  rgb_t                 bar_rgb_c, pix_rgb_c;

  assign vs_rise = in_vs && !vs_prev;

  // Position of the pixel currently presented on the inputs.
  always_comb begin
    pix_x   = '0;
    pix_y   = y_q;
    pix_cnt = '0;
    pix_idx = '0;
    if (vs_rise) begin
      pix_y = '0;
    end else if (state == ST_ACTIVE) begin
      pix_x = (x_q == CW'(H_ACTIVE - 1)) ? x_q : x_q + CW'(1);
      if (bar_cnt_q == BAR_CNT_W'(BAR_W - 1)) begin
        pix_idx = (bar_idx_q == BAR_IDX_W'(NUM_BARS - 1)) ? bar_idx_q
                                                           : bar_idx_q + BAR_IDX_W'(1);
      end else begin
        pix_cnt = bar_cnt_q + BAR_CNT_W'(1);
        pix_idx = bar_idx_q;
      end
    end
  end

  // Raster position FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_V_BLANK;
      vs_prev   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      vs_prev <= in_vs;
      if (vs_rise) begin
        state     <= ST_V_BLANK;
        x_q       <= '0;
        y_q       <= '0;
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
      end else begin
        case (state)
          ST_V_BLANK, ST_LINE_WAIT: begin
            if (in_de) begin
              state     <= ST_ACTIVE;
              x_q       <= pix_x;
              bar_cnt_q <= pix_cnt;
              bar_idx_q <= pix_idx;
            end
          end
          ST_ACTIVE: begin
            if (in_de) begin
              x_q       <= pix_x;
              bar_cnt_q <= pix_cnt;
              bar_idx_q <= pix_idx;
            end else begin
              state <= ST_LINE_WAIT;
              y_q   <= (y_q == CW'(V_ACTIVE - 1)) ? y_q : y_q + CW'(1);
            end
          end
          default: state <= ST_V_BLANK;
        endcase
      end
    end
  end

  // Overlay settings only change at frame boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_box_x      <= '0;
      sh_box_y      <= '0;
      sh_box_w      <= '0;
      sh_box_h      <= '0;
      sh_box_rgb    <= '0;
      sh_border_rgb <= '0;
      sh_blend      <= 1'b0;
    end else if (vs_rise) begin
      sh_box_x      <= box_x;
      sh_box_y      <= box_y;
      sh_box_w      <= box_w;
      sh_box_h      <= box_h;
      sh_box_rgb    <= box_rgb;
      sh_border_rgb <= border_rgb;
      sh_blend      <= blend_en;
    end
  end

  // Stage 1: timing, bar index and frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_de       <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_bar      <= '0;
      frame_start <= 1'b0;
    end else begin
      s1_de       <= in_de;
      s1_hs       <= in_hs;
      s1_vs       <= in_vs;
      s1_bar      <= pix_idx;
      frame_start <= vs_rise;
    end
  end

  overlay_box_cmp u_box_cmp (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (pix_x),
    .y         (pix_y),
    .box_x     (sh_box_x),
    .box_y     (sh_box_y),
    .box_w     (sh_box_w),
    .box_h     (sh_box_h),
    .in_box    (s1_in_box),
    .on_border (s1_on_border)
  );

  // Stage 2 colour select: border > fill (opaque or blended) > bar.
  always_comb begin
    bar_rgb_c = BAR_COLOURS[s1_bar];
    pix_rgb_c = bar_rgb_c;
    if (s1_on_border) begin
      pix_rgb_c = sh_border_rgb;
    end else if (s1_in_box) begin
      pix_rgb_c = sh_blend ? blend_half(sh_box_rgb, bar_rgb_c) : sh_box_rgb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_de <= 1'b0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_de <= s1_de;
      vga_hs <= s1_hs;
      vga_vs <= s1_vs;
      vga_r  <= s1_de ? pix_rgb_c.r : 8'h00;
      vga_g  <= s1_de ? pix_rgb_c.g : 8'h00;
      vga_b  <= s1_de ? pix_rgb_c.b : 8'h00;
    end
  end

endmodule

// File: tb/tb_overlay_pixel_gen.sv
// Directed self-checking bench for overlay_pixel_gen.
module tb_overlay_pixel_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_de, in_hs, in_vs;
  logic [11:0] box_x, box_y, box_w, box_h;
  logic [23:0] box_rgb, border_rgb;
  logic        blend_en;
  logic        vga_de, vga_hs, vga_vs;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  // Captured output line, indexed by active-pixel position.
  logic [23:0] line_px [0:2047];
  int mon_x = 0;
  int last_len = 0;
  int de_total = 0;

  always #5 clk = ~clk;

  overlay_pixel_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_de       (in_de),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .box_x       (box_x),
    .box_y       (box_y),
    .box_w       (box_w),
    .box_h       (box_h),
    .box_rgb     (box_rgb),
    .border_rgb  (border_rgb),
    .blend_en    (blend_en),
    .vga_de      (vga_de),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always @(negedge clk) begin
    if (vga_de) begin
      line_px[mon_x] = {vga_r, vga_g, vga_b};
      if (mon_x < 2047) mon_x = mon_x + 1;
      last_len = mon_x;
      de_total = de_total + 1;
    end else begin
      mon_x = 0;
    end
  end

  task automatic drive_line(input int n_act, input int n_blank);
    for (int i = 0; i < n_act; i++) begin
      in_de = 1'b1;
      @(negedge clk);
    end
    in_de = 1'b0;
    for (int j = 0; j < n_blank; j++) begin
      in_hs = (j == 1 || j == 2);
      @(negedge clk);
    end
    in_hs = 1'b0;
  endtask

  task automatic skip_lines(input int n);
    for (int i = 0; i < n; i++) drive_line(1, 3);
  endtask

  task automatic vsync();
    in_vs = 1'b1;
    repeat (3) @(negedge clk);
    in_vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_box(input int bx, input int by, input int bw, input int bh,
                         input logic [23:0] fill, input logic [23:0] brd, input logic bl);
    box_x = 12'(bx); box_y = 12'(by); box_w = 12'(bw); box_h = 12'(bh);
    box_rgb = fill; border_rgb = brd; blend_en = bl;
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    reset_n = 1'b0;
    in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
    set_box(0, 0, 50, 50, 24'h123456, 24'h654321, 1'b0);
    repeat (3) @(negedge clk);
    outs = {vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start};
    n_cmp++; if (outs !== 28'h0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", outs); end
    reset_n = 1'b1;
    @(negedge clk); in_de = 1'b1;
    @(negedge clk);
    n_cmp++; if (vga_de !== 1'b0) begin n_bad++; $display("FAIL de_latency_1 got %b want 0", vga_de); end
    @(negedge clk);
    n_cmp++; if (vga_de !== 1'b1) begin n_bad++; $display("FAIL de_latency_2 got %b want 1", vga_de); end
    // Geometry inputs are non-zero but shadows are still off: plain bar.
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 24'hFFFFFF) begin n_bad++; $display("FAIL first_pixel got %h want FFFFFF", {vga_r, vga_g, vga_b}); end
    reset_n = 1'b0; in_hs = 1'b1;
    #1;
    outs = {vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start};
    n_cmp++; if (outs !== 28'h0) begin n_bad++; $display("FAIL reset_midline got %h want 0", outs); end
    @(negedge clk);
    outs = {vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start};
    n_cmp++; if (outs !== 28'h0) begin n_bad++; $display("FAIL reset_held got %h want 0", outs); end
    in_hs = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (vga_de !== 1'b0) begin n_bad++; $display("FAIL rel_de_1 got %b want 0", vga_de); end
    @(negedge clk);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'hFFFFFF}) begin n_bad++; $display("FAIL rel_de_2 got %h want 1FFFFFF", {vga_de, vga_r, vga_g, vga_b}); end
    in_de = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_start_sync();
    in_vs = 1'b1;
    @(negedge clk);
    n_cmp++; if ({frame_start, vga_vs} !== 2'b10) begin n_bad++; $display("FAIL fs_pulse got %b want 10", {frame_start, vga_vs}); end
    @(negedge clk);
    n_cmp++; if ({frame_start, vga_vs} !== 2'b01) begin n_bad++; $display("FAIL fs_single got %b want 01", {frame_start, vga_vs}); end
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL fs_held got %b want 0", frame_start); end
    in_vs = 1'b0; in_hs = 1'b1;
    @(negedge clk); in_hs = 1'b0;
    n_cmp++; if (vga_hs !== 1'b0) begin n_bad++; $display("FAIL hs_delay_1 got %b want 0", vga_hs); end
    @(negedge clk);
    n_cmp++; if (vga_hs !== 1'b1) begin n_bad++; $display("FAIL hs_delay_2 got %b want 1", vga_hs); end
    @(negedge clk);
    n_cmp++; if (vga_hs !== 1'b0) begin n_bad++; $display("FAIL hs_delay_3 got %b want 0", vga_hs); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bars_full();
    int          xs [10] = '{0, 239, 240, 480, 720, 960, 1200, 1440, 1680, 1919};
    logic [23:0] ex [10] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};
    int de0;
    set_box(0, 0, 0, 0, 24'h0000FF, 24'hFF0000, 1'b0);
    vsync();
    de0 = de_total;
    drive_line(1920, 20);
    n_cmp++; if (last_len !== 1920) begin n_bad++; $display("FAIL bars_len got %0d want 1920", last_len); end
    foreach (xs[i]) begin
      n_cmp++; if (line_px[xs[i]] !== ex[i]) begin n_bad++; $display("FAIL bars_x%0d got %h want %h", xs[i], line_px[xs[i]], ex[i]); end
    end
    // Overlong line: x saturates at the last column, stays in the black bar.
    drive_line(1925, 8);
    n_cmp++; if (de_total - de0 !== 3845) begin n_bad++; $display("FAIL bars_de_count got %0d want 3845", de_total - de0); end
    n_cmp++; if (line_px[1924] !== 24'h000000) begin n_bad++; $display("FAIL bars_sat got %h want 000000", line_px[1924]); end
  endtask

  task automatic test_box_solid();
    int          xs [7] = '{101, 102, 250, 297, 298, 299, 300};
    logic [23:0] ex [7] = '{24'hFF0000, 24'h0000FF, 24'h0000FF, 24'h0000FF,
                            24'hFF0000, 24'hFF0000, 24'hFFFF00};
    set_box(100, 50, 200, 100, 24'h0000FF, 24'hFF0000, 1'b0);
    vsync();
    skip_lines(49);
    drive_line(320, 4);  // y=49, just above the box
    n_cmp++; if (line_px[100] !== 24'hFFFFFF) begin n_bad++; $display("FAIL solid_above got %h want FFFFFF", line_px[100]); end
    drive_line(320, 4);  // y=50, top border row
    n_cmp++; if (line_px[99] !== 24'hFFFFFF) begin n_bad++; $display("FAIL solid_left_out got %h want FFFFFF", line_px[99]); end
    n_cmp++; if (line_px[100] !== 24'hFF0000) begin n_bad++; $display("FAIL solid_100_50 got %h want FF0000", line_px[100]); end
    n_cmp++; if (line_px[150] !== 24'hFF0000) begin n_bad++; $display("FAIL solid_top got %h want FF0000", line_px[150]); end
    drive_line(320, 4);  // y=51
    n_cmp++; if (line_px[101] !== 24'hFF0000) begin n_bad++; $display("FAIL solid_101_51 got %h want FF0000", line_px[101]); end
    drive_line(320, 4);  // y=52, first fill row
    foreach (xs[i]) begin
      n_cmp++; if (line_px[xs[i]] !== ex[i]) begin n_bad++; $display("FAIL solid_y52_x%0d got %h want %h", xs[i], line_px[xs[i]], ex[i]); end
    end
  endtask

  task automatic test_blend_mid_change();
    int          xs [4] = '{100, 102, 250, 502};
    logic [23:0] ex [4] = '{24'hFF0000, 24'h7F7FFF, 24'h7F7F7F, 24'h00FFFF};
    int          xn [4] = '{102, 499, 500, 502};
    logic [23:0] en [4] = '{24'hFFFFFF, 24'h00FFFF, 24'hFF0000, 24'h0000FF};
    set_box(100, 50, 200, 100, 24'h0000FF, 24'hFF0000, 1'b1);
    vsync();
    skip_lines(52);
    box_x = 12'd500; blend_en = 1'b0;  // mid-frame change, must not apply yet
    drive_line(520, 4);
    foreach (xs[i]) begin
      n_cmp++; if (line_px[xs[i]] !== ex[i]) begin n_bad++; $display("FAIL blend_x%0d got %h want %h", xs[i], line_px[xs[i]], ex[i]); end
    end
    vsync();
    skip_lines(52);
    drive_line(520, 4);
    foreach (xn[i]) begin
      n_cmp++; if (line_px[xn[i]] !== en[i]) begin n_bad++; $display("FAIL next_frame_x%0d got %h want %h", xn[i], line_px[xn[i]], en[i]); end
    end
  endtask

  task automatic test_clip();
    set_box(1900, 1070, 100, 100, 24'h00FF00, 24'hFF00FF, 1'b0);
    vsync();
    skip_lines(1070);
    drive_line(1920, 4);  // y=1070, top border
    n_cmp++; if (line_px[1899] !== 24'h000000) begin n_bad++; $display("FAIL clip_left_out got %h want 000000", line_px[1899]); end
    n_cmp++; if (line_px[1900] !== 24'hFF00FF) begin n_bad++; $display("FAIL clip_top_left got %h want FF00FF", line_px[1900]); end
    n_cmp++; if (line_px[1919] !== 24'hFF00FF) begin n_bad++; $display("FAIL clip_top_right got %h want FF00FF", line_px[1919]); end
    skip_lines(1);
    drive_line(1920, 4);  // y=1072
    n_cmp++; if (line_px[0] !== 24'hFFFFFF) begin n_bad++; $display("FAIL clip_no_wrap got %h want FFFFFF", line_px[0]); end
    n_cmp++; if (line_px[1901] !== 24'hFF00FF) begin n_bad++; $display("FAIL clip_left_brd got %h want FF00FF", line_px[1901]); end
    n_cmp++; if (line_px[1902] !== 24'h00FF00) begin n_bad++; $display("FAIL clip_fill got %h want 00FF00", line_px[1902]); end
    n_cmp++; if (line_px[1919] !== 24'h00FF00) begin n_bad++; $display("FAIL clip_right_fill got %h want 00FF00", line_px[1919]); end
    skip_lines(6);
    drive_line(1920, 4);  // y=1079
    drive_line(1920, 4);  // y saturated at 1079
    n_cmp++; if (line_px[1919] !== 24'h00FF00) begin n_bad++; $display("FAIL clip_ysat got %h want 00FF00", line_px[1919]); end
    vsync();
    drive_line(1920, 4);  // y=0 of next frame
    n_cmp++; if (line_px[0] !== 24'hFFFFFF) begin n_bad++; $display("FAIL clip_next_x0 got %h want FFFFFF", line_px[0]); end
    n_cmp++; if (line_px[1919] !== 24'h000000) begin n_bad++; $display("FAIL clip_next_x1919 got %h want 000000", line_px[1919]); end
  endtask

  task automatic test_thin_box();
    int          xs [6] = '{99, 100, 101, 102, 103, 104};
    logic [23:0] ex [6] = '{24'hFFFFFF, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFFFFFF};
    set_box(100, 0, 4, 10, 24'h0000FF, 24'hFF0000, 1'b0);
    vsync();
    skip_lines(4);
    drive_line(110, 4);  // y=4, interior row
    foreach (xs[i]) begin
      n_cmp++; if (line_px[xs[i]] !== ex[i]) begin n_bad++; $display("FAIL thin_x%0d got %h want %h", xs[i], line_px[xs[i]], ex[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame_start_sync();
    test_bars_full();
    test_box_solid();
    test_blend_mid_change();
    test_clip();
    test_thin_box();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
